// File: rtl/alu_lockstep_pkg.sv
// Shared opcode encoding for the dual-lane lockstep ALU.
package alu_lockstep_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR = 3'd6;
    localparam logic [OP_W-1:0] OP_CMP = 3'd7;

endpackage

// File: rtl/alu_core.sv
// Single-lane combinational ALU: result plus one carry/flag bit per opcode.
module alu_core
    import alu_lockstep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  sel,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (sel)
            OP_ADD: {carry, res} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            OP_CMP: begin
                res   = {{(WIDTH-1){1'b0}}, (a == b)};
                carry = (a < b);
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_lockstep_n.sv
// Two-lane ALU with a two-stage pipeline; in lockstep mode the lanes are
// cross-checked and disagreements feed a sticky flag and a saturating counter.
module alu_lockstep_n
    import alu_lockstep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    input  logic [OP_W-1:0]  sel0_i,
    input  logic [OP_W-1:0]  sel1_i,
    input  logic             mode_i,
    input  logic             err_clr_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] out0_o,
    output logic [WIDTH-1:0] out1_o,
    output logic             carry0_o,
    output logic             carry1_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             carry_diff_o,
    output logic             mismatch_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] mismatch_cnt_o
);

    localparam int NUM_LANES = 2;
    localparam int STAGES    = 2;

    logic [STAGES:1]                     vld_pipe;
    logic [NUM_LANES-1:0][WIDTH-1:0]     s1_a, s1_b;
    logic [NUM_LANES-1:0][OP_W-1:0]      s1_sel;
    logic                                s1_mode;

    logic [NUM_LANES-1:0][WIDTH-1:0]     res;
    logic [NUM_LANES-1:0]                carry;
    logic [WIDTH-1:0]                    diff_n;
    logic                                cdiff_n;
    logic                                mm_n;

    logic [NUM_LANES-1:0][WIDTH-1:0]     s2_out;
    logic [NUM_LANES-1:0]                s2_carry;
    logic [WIDTH-1:0]                    s2_diff;
    logic                                s2_cdiff;
    logic                                s2_mm;

    logic                                sticky;
    logic [CNT_W-1:0]                    cnt;
    logic                                hit;

    // Stage 1: capture operand set and mode together so mode is per transaction.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vld_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            s1_mode  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
            if (valid_i) begin
                s1_a    <= {a1_i, a0_i};
                s1_b    <= {b1_i, b0_i};
                s1_sel  <= {sel1_i, sel0_i};
                s1_mode <= mode_i;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        alu_core #(.WIDTH(WIDTH)) u_core (
            .a     (s1_a[l]),
            .b     (s1_b[l]),
            .sel   (s1_sel[l]),
            .res   (res[l]),
            .carry (carry[l])
        );
    end

    always_comb begin
        diff_n  = res[0] ^ res[1];
        cdiff_n = carry[0] ^ carry[1];
        mm_n    = !s1_mode && ((diff_n != '0) || cdiff_n);
    end

    // Stage 2: only loaded by a valid set, so outputs hold between results.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s2_out   <= '0;
            s2_carry <= '0;
            s2_diff  <= '0;
            s2_cdiff <= 1'b0;
            s2_mm    <= 1'b0;
        end else if (vld_pipe[1]) begin
            s2_out   <= res;
            s2_carry <= carry;
            s2_diff  <= diff_n;
            s2_cdiff <= cdiff_n;
            s2_mm    <= mm_n;
        end
    end

    assign hit = vld_pipe[STAGES] && s2_mm;

    // A clear that lands on a mismatch restarts the count at that event.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (err_clr_i) begin
            cnt    <= hit ? CNT_W'(1) : '0;
            sticky <= hit;
        end else if (hit) begin
            sticky <= 1'b1;
            if (!(&cnt))
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign valid_o        = vld_pipe[STAGES];
    assign out0_o         = s2_out[0];
    assign out1_o         = s2_out[1];
    assign carry0_o       = s2_carry[0];
    assign carry1_o       = s2_carry[1];
    assign diff_o         = s2_diff;
    assign carry_diff_o   = s2_cdiff;
    assign mismatch_o     = s2_mm;
    assign err_sticky_o   = sticky;
    assign mismatch_cnt_o = cnt;

endmodule

// File: tb/tb_alu_lockstep_n.sv
// Directed plus random checks of alu_lockstep_n against a cycle-level reference model.
module tb_alu_lockstep_n;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          valid_i = 1'b0, mode_i = 1'b0, err_clr_i = 1'b0;
    logic [W-1:0]  a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
    logic [2:0]    sel0_i = '0, sel1_i = '0;
    logic          valid_o, carry0_o, carry1_o, carry_diff_o, mismatch_o, err_sticky_o;
    logic [W-1:0]  out0_o, out1_o, diff_o;
    logic [CW-1:0] mismatch_cnt_o;

    alu_lockstep_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .valid_i(valid_i),
        .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
        .sel0_i(sel0_i), .sel1_i(sel1_i), .mode_i(mode_i), .err_clr_i(err_clr_i),
        .valid_o(valid_o), .out0_o(out0_o), .out1_o(out1_o),
        .carry0_o(carry0_o), .carry1_o(carry1_o), .diff_o(diff_o),
        .carry_diff_o(carry_diff_o), .mismatch_o(mismatch_o),
        .err_sticky_o(err_sticky_o), .mismatch_cnt_o(mismatch_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit vld; int a0, b0, s0, a1, b1, s1; bit mode, clr, rst;
    } txn_t;
    txn_t q[$];

    int e_vld, e_out0, e_out1, e_c0, e_c1, e_diff, e_cd, e_mm, e_cnt, e_sticky;
    bit prev_hit;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns carry*2^W + result.
    function automatic int ref_alu(input int a, input int b, input int op);
        int r, c;
        r = 0; c = 0;
        case (op)
            0: begin r = a + b; c = (r > MASK); r = r & MASK; end
            1: begin r = (a - b) & MASK; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) & MASK; c = (a >= (1 << (W-1))); end
            6: begin r = a / 2; c = a % 2; end
            default: begin r = (a == b); c = (a < b); end
        endcase
        return c * (1 << W) + r;
    endfunction

    task automatic model_and_check();
        txn_t cur, t;
        int r0, r1;
        cur = q[q.size()-1];
        if (cur.rst) begin
            e_vld = 0; e_out0 = 0; e_out1 = 0; e_c0 = 0; e_c1 = 0;
            e_diff = 0; e_cd = 0; e_mm = 0; e_cnt = 0; e_sticky = 0;
            prev_hit = 0;
            foreach (q[i]) q[i].vld = 0;
        end else begin
            if (cur.clr) begin
                e_cnt = prev_hit; e_sticky = prev_hit;
            end else if (prev_hit) begin
                if (e_cnt < CMAX) e_cnt++;
                e_sticky = 1;
            end
            e_vld = 0;
            if (q.size() >= 2 && q[q.size()-2].vld) begin
                t = q[q.size()-2];
                r0 = ref_alu(t.a0, t.b0, t.s0);
                r1 = ref_alu(t.a1, t.b1, t.s1);
                e_vld  = 1;
                e_out0 = r0 & MASK;  e_c0 = r0 >> W;
                e_out1 = r1 & MASK;  e_c1 = r1 >> W;
                e_diff = e_out0 ^ e_out1;
                e_cd   = e_c0 ^ e_c1;
                e_mm   = (!t.mode && (e_diff != 0 || e_cd != 0)) ? 1 : 0;
            end
            prev_hit = (e_vld != 0) && (e_mm != 0);
        end
        while (q.size() > 2) void'(q.pop_front());
        chk("valid_o", int'(valid_o), e_vld);
        chk("out0", int'(out0_o), e_out0);
        chk("out1", int'(out1_o), e_out1);
        chk("carry0", int'(carry0_o), e_c0);
        chk("carry1", int'(carry1_o), e_c1);
        chk("diff", int'(diff_o), e_diff);
        chk("carry_diff", int'(carry_diff_o), e_cd);
        chk("mismatch", int'(mismatch_o), e_mm);
        chk("sticky", int'(err_sticky_o), e_sticky);
        chk("cnt", int'(mismatch_cnt_o), e_cnt);
    endtask

    // Drive one cycle of inputs, clock it, then check against the model.
    task automatic apply(input bit v, input int a0, input int b0, input int s0,
                         input int a1, input int b1, input int s1,
                         input bit mode, input bit clr, input bit rst);
        txn_t t;
        valid_i = v; a0_i = W'(a0); b0_i = W'(b0); sel0_i = 3'(s0);
        a1_i = W'(a1); b1_i = W'(b1); sel1_i = 3'(s1);
        mode_i = mode; err_clr_i = clr; wb_rst_i = rst;
        t.vld = v; t.a0 = a0; t.b0 = b0; t.s0 = s0; t.a1 = a1; t.b1 = b1; t.s1 = s1;
        t.mode = mode; t.clr = clr; t.rst = rst;
        q.push_back(t);
        @(posedge wb_clk_i);
        #1;
        model_and_check();
    endtask

    task automatic idle(input bit clr);
        apply(0, 0, 0, 0, 0, 0, 0, 0, clr, 0);
    endtask

    initial begin
        int run, a, b, op, vcount;
        // Reset
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_cnt", int'(mismatch_cnt_o), 0);

        // Matching ADD with carry out
        apply(1, 'hF0, 'h20, 0, 'hF0, 'h20, 0, 0, 0, 0);
        idle(0);
        chk("add_valid", int'(valid_o), 1);
        chk("add_out0", int'(out0_o), 'h10);
        chk("add_carry0", int'(carry0_o), 1);
        chk("add_diff", int'(diff_o), 0);
        chk("add_mm", int'(mismatch_o), 0);
        idle(0);

        // ADD vs SUB in lockstep: mismatch
        apply(1, 3, 4, 0, 3, 4, 1, 0, 0, 0);
        idle(0);
        chk("ls_out0", int'(out0_o), 'h07);
        chk("ls_out1", int'(out1_o), 'hFF);
        chk("ls_carry1", int'(carry1_o), 1);
        chk("ls_diff", int'(diff_o), 'hF8);
        chk("ls_cdiff", int'(carry_diff_o), 1);
        chk("ls_mm", int'(mismatch_o), 1);
        idle(0);
        chk("ls_sticky", int'(err_sticky_o), 1);
        chk("ls_cnt", int'(mismatch_cnt_o), 1);

        // Same in independent mode: diff still reported, no mismatch
        apply(1, 3, 4, 0, 3, 4, 1, 1, 0, 0);
        idle(0);
        chk("ind_diff", int'(diff_o), 'hF8);
        chk("ind_mm", int'(mismatch_o), 0);
        idle(0);
        chk("ind_cnt", int'(mismatch_cnt_o), 1);
        chk("ind_sticky", int'(err_sticky_o), 1);

        // Saturation after 20 back-to-back mismatches
        for (int i = 0; i < 20; i++) apply(1, i, 4, 0, i, 4, 1, 0, 0, 0);
        idle(0); idle(0); idle(0);
        chk("sat_cnt", int'(mismatch_cnt_o), CMAX);
        // Clear coincident with a mismatch keeps the new event
        apply(1, 3, 4, 0, 3, 4, 1, 0, 0, 0);
        idle(0);
        idle(1);
        chk("clrhit_cnt", int'(mismatch_cnt_o), 1);
        chk("clrhit_sticky", int'(err_sticky_o), 1);
        idle(1);
        chk("clr_cnt", int'(mismatch_cnt_o), 0);
        chk("clr_sticky", int'(err_sticky_o), 0);

        // Reset while a transaction is in flight
        apply(1, 'h55, 'h0F, 2, 'h55, 'h0F, 3, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("flush_valid", int'(valid_o), 0);
            chk("flush_out1", int'(out1_o), 0);
        end

        // Four back-to-back transactions, in order
        vcount = 0;
        apply(1, 'h11, 'h22, 0, 'h11, 'h22, 0, 0, 0, 0);
        apply(1, 'h81, 'h00, 5, 'h81, 'h00, 6, 1, 0, 0);
        if (valid_o) vcount++;
        apply(1, 'h40, 'h40, 7, 'h40, 'h41, 7, 0, 0, 0);
        if (valid_o) vcount++;
        apply(1, 'hA5, 'h5A, 4, 'hA5, 'h5A, 4, 0, 0, 0);
        if (valid_o) vcount++;
        idle(0);
        if (valid_o) vcount++;
        idle(0);
        if (valid_o) vcount++;
        chk("b2b_out0_last", int'(out0_o), 'hFF);
        idle(0);
        chk("b2b_count", vcount, 4);
        chk("b2b_hold", int'(out0_o), 'hFF);

        // Randomized traffic including mode flips, clears and resets
        for (run = 0; run < 400; run++) begin
            a  = int'($urandom_range(0, MASK));
            b  = int'($urandom_range(0, MASK));
            op = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                apply($urandom_range(0, 3) != 0, a, b, op, a, b, op,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 63) == 0);
            else
                apply($urandom_range(0, 3) != 0, a, b, op,
                      int'($urandom_range(0, MASK)), b, int'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 63) == 0);
        end
        idle(0); idle(0); idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_n.md
ALU_LOCKSTEP_N -- requirements
Module: alu_lockstep_n

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width per lane, legal values 4..32.
REQ-002 Parameter CNT_W, default 16: mismatch counter width, legal values 2..32.
REQ-003 wb_clk_i  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  operand set is valid this cycle.
REQ-006 a0_i, b0_i, a1_i, b1_i  in  WIDTH each  lane-0 and lane-1 operands.
REQ-007 sel0_i, sel1_i  in  3 each  lane-0 and lane-1 opcodes.
REQ-008 mode_i  in  1  0 = lockstep (compare lanes), 1 = independent (no compare).
REQ-009 err_clr_i  in  1  clears the sticky error flag and the mismatch counter.
REQ-010 valid_o  out  1  result set is valid.
REQ-011 out0_o, out1_o  out  WIDTH each  lane results.
REQ-012 carry0_o, carry1_o  out  1 each  lane carry/flag bits.
REQ-013 diff_o  out  WIDTH  out0 XOR out1.
REQ-014 carry_diff_o  out  1  carry0 XOR carry1.
REQ-015 mismatch_o  out  1  lanes disagree in lockstep mode; qualified by valid_o.
REQ-016 err_sticky_o  out  1  at least one mismatch since the last reset or clear.
REQ-017 mismatch_cnt_o  out  CNT_W  saturating count of mismatches.

Function
REQ-018 Opcodes SHALL be: 0 ADD {c,r}=a+b; 1 SUB r=a-b, c=(a<b); 2 AND; 3 OR; 4 XOR (c=0 for 2..4); 5 SHL r=a<<1, c=a[MSB]; 6 SHR r=a>>1, c=a[0]; 7 CMP r=(a==b) zero-extended, c=(a<b) unsigned.
REQ-019 Stage 1 SHALL register valid_i, operands, opcodes and mode_i; stage 2 SHALL register lane results, carries, diff, carry_diff and mismatch.
REQ-020 Latency SHALL be exactly 2 cycles from valid_i to valid_o, with throughput of one set per cycle, in order.
REQ-021 Data outputs SHALL hold their last values while valid_o=0.
REQ-022 mismatch SHALL equal (diff!=0 OR carry_diff) when the registered mode=0, and SHALL be 0 when mode=1; diff_o and carry_diff_o SHALL be produced in both modes.
REQ-023 On valid_o AND mismatch_o, err_sticky_o SHALL be set and the counter SHALL increment, saturating at 2^CNT_W-1 with no wrap.
REQ-024 err_clr_i alone SHALL zero the counter and the sticky flag on the next edge.
REQ-025 err_clr_i coincident with a valid mismatch SHALL leave the counter at 1 and the sticky flag at 1, so the new event is not lost.
REQ-026 mode_i SHALL be sampled per transaction, so a mode change mid-stream affects only the transactions issued after it.

Reset
REQ-027 While wb_rst_i=1, all pipeline valids, data outputs, flags and the counter SHALL be 0 on the next edge; in-flight transactions SHALL be discarded.
REQ-028 Reset SHALL take priority over valid_i and err_clr_i.

Structure
REQ-029 Package alu_lockstep_pkg SHALL hold the opcode constants (OP_ADD..OP_CMP) and the opcode width (3).
REQ-030 Sub-module alu_core (combinational, parameter WIDTH) SHALL implement REQ-018 and SHALL be instantiated once per lane.

Verification (WIDTH=8)
REQ-031 Both lanes ADD 0xF0+0x20, mode 0 -> two cycles later valid_o=1, out=0x10, carry=1, diff=0x00, mismatch=0.
REQ-032 Lane 0 ADD and lane 1 SUB on 0x03, 0x04, mode 0 -> out0=0x07, out1=0xFF, carry1=1, diff=0xF8, carry_diff=1, mismatch=1, sticky=1, cnt=1.
REQ-033 Same stimulus with mode 1 -> diff=0xF8, mismatch=0, cnt and sticky unchanged.
REQ-034 CNT_W=4, 20 back-to-back mismatches -> cnt=0xF and holds there; then err_clr_i coincident with a mismatch -> cnt=1, sticky=1.
REQ-035 valid_i at cycle n, wb_rst_i at n+1 -> valid_o never asserts and all outputs are 0.
REQ-036 Four back-to-back transactions with distinct operands -> valid_o high for four consecutive cycles with results in issue order.
